// File: rtl/caf_pkg.sv
// caf_pkg: shared types and default widths for the CAF reference path
package caf_pkg;
  localparam int CAF_INDEX_BITS = 10;
  localparam int CAF_I_BITS = 12;
  localparam int CAF_Q_BITS = 12;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} stream_state_e;
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: power-of-two synchronous FIFO with occupancy count and clear
module stream_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full, do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(DEPTH);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  // next storage, pointers and occupancy; clear overrides any push/pop
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = clear ? '0 : wr_q + AW'(do_push);
    rd_d = clear ? '0 : rd_q + AW'(do_pop);
    cnt_d = clear ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/reference_streamer.sv
// reference_streamer: sweeps reference_buffer reads into a credit-managed I/Q stream
module reference_streamer
  import caf_pkg::*;
#(
  parameter int I_BITS = CAF_I_BITS,
  parameter int Q_BITS = CAF_Q_BITS,
  parameter int INDEX_BITS = CAF_INDEX_BITS,
  parameter int BUFFER_LENGTH = 1000,
  parameter int SWEEP_LENGTH = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [INDEX_BITS-1:0] start_index,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [INDEX_BITS-1:0] m_axi_raddr,
  output logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic                  s_axi_rready,
  input  logic                  s_axi_rvalid,
  input  logic [I_BITS-1:0]     i,
  input  logic [Q_BITS-1:0]     q,
  output logic [I_BITS-1:0]     out_i,
  output logic [Q_BITS-1:0]     out_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);
  localparam int CW = $clog2(SWEEP_LENGTH+1);
  localparam int OW = $clog2(FIFO_DEPTH+1);
  localparam int DW = I_BITS + Q_BITS;
  stream_state_e state_q, state_d;
  logic [INDEX_BITS-1:0] addr_q, addr_d;
  logic [CW-1:0] issued_q, issued_d, delivered_q, delivered_d;
  logic [OW-1:0] outstanding_q, outstanding_d, fifo_count;
  logic err_q, err_d;
  logic [DW-1:0] fifo_dout;
  logic fifo_empty, active, kill, credit, accept, push, pop;
  assign active = state_q == FETCH || state_q == DRAIN;
  assign kill = active && abort;
  assign credit = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (OW+1)'(FIFO_DEPTH);
  assign m_axi_rvalid = state_q == FETCH && credit && issued_q < CW'(SWEEP_LENGTH);
  assign accept = m_axi_rvalid && s_axi_rready;
  assign push = s_axi_rvalid && active && !abort;
  assign out_valid = !fifo_empty;
  assign pop = out_valid && out_ready;
  assign out_last = out_valid && delivered_q == CW'(SWEEP_LENGTH-1);
  assign out_i = out_valid ? fifo_dout[DW-1:Q_BITS] : '0;
  assign out_q = out_valid ? fifo_dout[Q_BITS-1:0] : '0;
  assign m_axi_raddr = addr_q;
  assign m_axi_rready = state_q != IDLE;
  assign busy = state_q != IDLE;
  assign done = state_q == DRAIN && delivered_q == CW'(SWEEP_LENGTH);
  assign err = err_q;
  stream_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .clear(kill), .push(push), .pop(pop),
    .din({i, q}), .dout(fifo_dout), .count(fifo_count), .empty(fifo_empty)
  );
  // sweep control, address walk and credit bookkeeping
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    issued_d = issued_q;
    delivered_d = delivered_q + CW'(pop);
    outstanding_d = outstanding_q + OW'(accept) - OW'(s_axi_rvalid && outstanding_q != '0);
    err_d = 1'b0;
    if (accept) begin
      issued_d = issued_q + 1'b1;
      addr_d = addr_q == INDEX_BITS'(BUFFER_LENGTH-1) ? '0 : addr_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (start && 32'(start_index) < BUFFER_LENGTH) begin
          state_d = FETCH;
          addr_d = start_index;
          issued_d = '0;
          delivered_d = '0;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      FETCH: state_d = abort ? FLUSH : issued_d == CW'(SWEEP_LENGTH) ? DRAIN : FETCH;
      DRAIN: state_d = abort ? FLUSH : delivered_q == CW'(SWEEP_LENGTH) ? IDLE : DRAIN;
      FLUSH: state_d = outstanding_q == '0 ? IDLE : FLUSH;
    endcase
  end
  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      issued_q <= '0;
      delivered_q <= '0;
      outstanding_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      issued_q <= issued_d;
      delivered_q <= delivered_d;
      outstanding_q <= outstanding_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_reference_streamer.sv
// tb_reference_streamer: randomized sweeps against a queue-based buffer and stream model
module tb_reference_streamer;
  localparam int BL = 8;
  localparam int SL = 8;
  localparam int FD = 4;
  typedef struct {int due; int a;} rq_t;
  logic clk = 0, rst = 1, start = 0, abort = 0, s_axi_rready = 0, s_axi_rvalid = 0, out_ready = 0;
  logic [3:0] start_index = 0;
  logic [11:0] i = 0, q = 0;
  logic busy, done, err, m_axi_rvalid, m_axi_rready, out_valid, out_last;
  logic [3:0] m_axi_raddr;
  logic [11:0] out_i, out_q;
  logic [34:0] outs;
  int total = 0, bad = 0;
  int cyc = 0, lat_lo = 1, lat_hi = 1, rr = 100, orp = 100, stall_n = 0;
  int buffered = 0, issued_cnt = SL, next_addr = 0, npop = 0, k = 0;
  bit flushing = 0, done_exp = 0, done_seen = 0, err_exp = 0, pv_stall = 0, pv_req = 0;
  logic [23:0] pv_data;
  logic [3:0] pv_addr;
  rq_t reqq[$];
  logic [23:0] expq[$];
  assign outs = {busy, done, err, m_axi_rvalid, m_axi_rready, out_valid, out_last, m_axi_raddr, out_i, out_q};
  reference_streamer #(.I_BITS(12), .Q_BITS(12), .INDEX_BITS(4), .BUFFER_LENGTH(BL),
                       .SWEEP_LENGTH(SL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .start_index(start_index), .abort(abort),
    .busy(busy), .done(done), .err(err), .m_axi_raddr(m_axi_raddr), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .s_axi_rready(s_axi_rready), .s_axi_rvalid(s_axi_rvalid),
    .i(i), .q(q), .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic acc, rsp, pop;
    logic [23:0] e;
    int due;
    @(negedge clk);
    chk("done", done, done_exp);
    if (done_exp) done_seen = 1;
    done_exp = 0;
    chk("err", err, err_exp);
    err_exp = 0;
    if (pv_stall) begin
      chk("hold_v", out_valid, 1);
      chk("hold_d", {out_i, out_q}, pv_data);
    end
    if (pv_req) chk("req_hold", {m_axi_rvalid, m_axi_raddr}, {1'b1, pv_addr});
    if (m_axi_rvalid) chk("credit", reqq.size() + buffered < FD, 1);
    acc = m_axi_rvalid && s_axi_rready;
    rsp = s_axi_rvalid;
    pop = out_valid && out_ready;
    if (acc) begin
      chk("nreq", issued_cnt < SL, 1);
      chk("raddr", m_axi_raddr, next_addr);
    end
    if (pop) begin
      if (expq.size() == 0) chk("spurious", 1, 0);
      else begin
        e = expq.pop_front();
        chk("data", {out_i, out_q}, e);
        chk("last", out_last, npop == SL - 1);
        npop++;
        if (npop == SL) done_exp = 1;
      end
    end
    pv_stall = out_valid && !out_ready && !abort;
    pv_data = {out_i, out_q};
    pv_req = m_axi_rvalid && !s_axi_rready && !abort;
    pv_addr = m_axi_raddr;
    @(posedge clk);
    cyc++;
    if (acc) begin
      due = cyc + $urandom_range(lat_hi, lat_lo) - 1;
      if (reqq.size() > 0 && due <= reqq[$].due) due = reqq[$].due + 1;
      reqq.push_back('{due, next_addr});
      issued_cnt++;
      next_addr = (next_addr + 1) % BL;
    end
    if (rsp && reqq.size() > 0) begin
      void'(reqq.pop_front());
      if (!flushing) buffered++;
    end
    if (pop) buffered--;
    #1;
    s_axi_rready = $urandom_range(0, 99) < rr;
    if (reqq.size() > 0 && reqq[0].due <= cyc) begin
      s_axi_rvalid = 1;
      i = 12'(reqq[0].a);
      q = 12'(-reqq[0].a);
    end else begin
      s_axi_rvalid = 0;
      i = 12'($urandom);
      q = 12'($urandom);
    end
    if (stall_n > 0) begin
      out_ready = 0;
      stall_n--;
    end else out_ready = $urandom_range(0, 99) < orp;
  endtask
  task automatic begin_sweep(input int s);
    flushing = 0;
    expq.delete();
    for (int n = 0; n < SL; n++) expq.push_back({12'((s + n) % BL), 12'(-((s + n) % BL))});
    npop = 0;
    issued_cnt = 0;
    next_addr = s;
    done_seen = 0;
    start = 1;
    start_index = 4'(s);
    tick();
    start = 0;
    chk("busy_up", busy, 1);
  endtask
  task automatic sweep(input int s, input int stall_at, output int n);
    begin_sweep(s);
    n = 0;
    while (!done_seen && n < 400) begin
      n++;
      if (n == stall_at) stall_n = 10;
      start = n == 5;
      if (n == 5) start_index = 4'($urandom);
      tick();
    end
    start = 0;
    if (!done_seen) chk("timeout", 0, 1);
    chk("busy_dn", busy, 0);
    chk("left", expq.size(), 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", outs, 0);
    @(posedge clk);
    #1 rst = 0;
    sweep(0, 0, k);
    chk("b2b_cycles", k, 11);
    sweep(6, 0, k);
    lat_lo = 3; lat_hi = 3;
    sweep(2, 4, k);
    issued_cnt = SL;
    start = 1;
    start_index = 4'(8 + $urandom_range(0, 7));
    tick();
    start = 0;
    err_exp = 1;
    chk("err_busy", busy, 0);
    tick();
    chk("err_idle", busy, 0);
    tick();
    lat_lo = 4; lat_hi = 4;
    begin_sweep(0);
    k = 0;
    while (npop < 3 && k < 100) begin k++; tick(); end
    out_ready = 0;
    abort = 1;
    flushing = 1;
    expq.delete();
    buffered = 0;
    tick();
    abort = 0;
    issued_cnt = SL;
    chk("abort_ov", out_valid, 0);
    chk("abort_rv", m_axi_rvalid, 0);
    k = 0;
    while (reqq.size() > 0 && k < 50) begin chk("flush_busy", busy, 1); k++; tick(); end
    k = 0;
    while (busy && k < 5) begin k++; tick(); end
    chk("flush_end", busy, 0);
    lat_lo = 1; lat_hi = 1;
    sweep(0, 0, k);
    lat_lo = 3; lat_hi = 3;
    begin_sweep(0);
    repeat (3) tick();
    rst = 1;
    #1 chk("rst_out", outs, 0);
    reqq.delete();
    expq.delete();
    buffered = 0;
    done_exp = 0;
    pv_stall = 0;
    pv_req = 0;
    issued_cnt = SL;
    s_axi_rvalid = 0;
    repeat (2) tick();
    rst = 0;
    chk("rst_busy", busy, 0);
    sweep(3, 0, k);
    for (int r = 0; r < 6; r++) begin
      lat_lo = 1;
      lat_hi = $urandom_range(1, 5);
      rr = $urandom_range(30, 100);
      orp = $urandom_range(30, 100);
      sweep($urandom_range(0, BL - 1), $urandom_range(3, 12), k);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
